// File: rtl/cycle_controller.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> (WB),
// with bounded memory waits, a sticky fault state and a retired-instruction count.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for run; no requests or strobes
// FETCH  | instruction fetch outstanding; ir_wr when imem_ready arrives
// DECODE | one-cycle decode slot, no strobes
// EXEC   | classify instruction; branches retire here
// MEM    | data access outstanding; stores retire on dmem_ready
// WB     | register writeback; every non-branch, non-store retires here
// FAULT  | illegal op or memory timeout; held until reset
module cycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        branch_stmt,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic        mem_to_reg,
  input  logic        Reg_Wr,
  input  logic        branch_taken,
  output logic        imem_req,
  output logic        ir_wr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_wr,
  output logic        wb_sel_mem,
  output logic        pc_wr,
  output logic        pc_src_branch,
  output logic        fault,
  output logic [2:0]  state,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_FAULT   = 3'd6,
    S_ILLEGAL = 3'd7
  } state_t;

  // Wait-counter value in the last cycle a memory may still answer.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] wait_cnt;
  logic       wait_clr;
  logic       wait_inc;
  logic       retire;

  assign state = state_q;

  // Next-state decode and all control outputs; retire overrides the next state.
  always_comb begin
    state_d       = state_q;
    imem_req      = 1'b0;
    ir_wr         = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    rf_wr         = 1'b0;
    wb_sel_mem    = 1'b0;
    pc_wr         = 1'b0;
    pc_src_branch = 1'b0;
    fault         = 1'b0;
    retire        = 1'b0;
    wait_inc      = 1'b0;
    wait_clr      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_wr   = 1'b1;
          state_d = S_DECODE;
        end else begin
          wait_inc = 1'b1;
          if (wait_cnt == WAIT_LAST) state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (mem_rd && mem_wr) begin
          state_d = S_FAULT;
        end else if (mem_rd || mem_wr) begin
          state_d = S_MEM;
        end else if (branch_stmt) begin
          pc_wr         = 1'b1;
          pc_src_branch = branch_taken;
          retire        = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = mem_wr;
        if (dmem_ready) begin
          if (mem_wr) begin
            pc_wr  = 1'b1;
            retire = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else begin
          wait_inc = 1'b1;
          if (wait_cnt == WAIT_LAST) state_d = S_FAULT;
        end
      end
      S_WB: begin
        rf_wr      = Reg_Wr;
        wb_sel_mem = mem_to_reg;
        pc_wr      = 1'b1;
        retire     = 1'b1;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase

    if (retire) state_d = run ? S_FETCH : S_IDLE;

    // Each fresh wait window (fetch or data access) starts from zero.
    if ((state_d == S_FETCH && state_q != S_FETCH) ||
        (state_d == S_MEM && state_q != S_MEM)) begin
      wait_clr = 1'b1;
    end
  end

  // State, wait counter and retire counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      state_q <= state_d;
      if (wait_clr) begin
        wait_cnt <= '0;
      end else if (wait_inc) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (retire) retired <= retired + 32'd1;
    end
  end

endmodule

// File: tb/tb_cycle_controller.sv
// Bench for cycle_controller: instruction table with a retire scoreboard,
// plus hand sequences for memory waits, timeouts, faults, reset and wrap.
module tb_cycle_controller;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_FAULT = 3'd6;

  logic clk = 1'b0;
  logic reset, run, imem_ready, dmem_ready, branch_stmt, mem_rd, mem_wr;
  logic mem_to_reg, Reg_Wr, branch_taken;
  logic imem_req, ir_wr, dmem_req, dmem_we, rf_wr, wb_sel_mem, pc_wr;
  logic pc_src_branch, fault;
  logic [2:0]  state;
  logic [31:0] retired;

  typedef struct {
    int         id;
    logic       br, tk, rd, wr, m2r, rw;
    int         lat;
    logic [2:0] fin;
    logic       rf, wb, src, we;
  } vec_t;

  vec_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_retire_seen = 0;
  logic [31:0] exp_retired = '0;

  cycle_controller #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .run(run), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .branch_stmt(branch_stmt), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_to_reg(mem_to_reg), .Reg_Wr(Reg_Wr),
    .branch_taken(branch_taken), .imem_req(imem_req), .ir_wr(ir_wr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_wr(rf_wr),
    .wb_sel_mem(wb_sel_mem), .pc_wr(pc_wr), .pc_src_branch(pc_src_branch),
    .fault(fault), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %s", name, what);
  endtask

  function automatic vec_t mk(input int id, input logic [5:0] in, input int lat,
                              input logic [2:0] fin, input logic [3:0] out);
    vec_t v;
    v.id = id;
    {v.br, v.tk, v.rd, v.wr, v.m2r, v.rw} = in;
    v.lat = lat;
    v.fin = fin;
    {v.rf, v.wb, v.src, v.we} = out;
    return v;
  endfunction

  // Retire monitor: instruction length and retire-cycle outputs against the scoreboard.
  int         cyc = 0;
  logic [2:0] prev_state = S_IDLE;
  always @(negedge clk) begin
    vec_t e;
    if (reset) begin
      cyc        = 0;
      prev_state = S_IDLE;
    end else begin
      if (state == S_FETCH && prev_state != S_FETCH) cyc = 1;
      else if (state != S_IDLE && state != S_FAULT) cyc++;
      if (pc_wr) begin
        n_retire_seen++;
        if (exp_q.size() == 0) begin
          fail_now("unexpected_retire", "pc_wr with nothing outstanding");
        end else begin
          e = exp_q.pop_front();
          check($sformatf("v%0d_latency", e.id), 32'(cyc), 32'(e.lat));
          check($sformatf("v%0d_retire_state", e.id), 32'(state), 32'(e.fin));
          check($sformatf("v%0d_rf_wr", e.id), 32'(rf_wr), 32'(e.rf));
          check($sformatf("v%0d_wb_sel_mem", e.id), 32'(wb_sel_mem), 32'(e.wb));
          check($sformatf("v%0d_pc_src_branch", e.id), 32'(pc_src_branch), 32'(e.src));
          check($sformatf("v%0d_dmem_we", e.id), 32'(dmem_we), 32'(e.we));
        end
      end
      prev_state = state;
    end
  end

  task automatic wait_retire(input int tgt);
    for (int i = 0; i < 40 && n_retire_seen < tgt; i++) begin
      @(negedge clk); #1;
    end
    if (n_retire_seen < tgt) fail_now("retire_timeout", "no pc_wr within 40 cycles");
    @(negedge clk); #1;
    exp_retired = exp_retired + 32'd1;
    check("retired_count", retired, exp_retired);
  endtask

  task automatic set_dec(input logic [5:0] in);
    {branch_stmt, branch_taken, mem_rd, mem_wr, mem_to_reg, Reg_Wr} = in;
  endtask

  task automatic do_instr(input vec_t v);
    int tgt;
    set_dec({v.br, v.tk, v.rd, v.wr, v.m2r, v.rw});
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    run        = 1'b1;
    tgt        = n_retire_seen + 1;
    exp_q.push_back(v);
    wait_retire(tgt);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    exp_q.delete();
    exp_retired = '0;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int   n, tgt;
    logic req_ok;

    // {br,tk,rd,wr,m2r,rw}, latency, retire state, {rf_wr,wb_sel,pc_src,dmem_we}
    vecs[0] = mk(0, 6'b000001, 4, S_WB,   4'b1000);  // ALU, writes rf
    vecs[1] = mk(1, 6'b000000, 4, S_WB,   4'b0000);  // ALU, no write
    vecs[2] = mk(2, 6'b000011, 4, S_WB,   4'b1100);  // ALU with mem_to_reg set
    vecs[3] = mk(3, 6'b001011, 5, S_WB,   4'b1100);  // load
    vecs[4] = mk(4, 6'b000100, 4, S_MEM,  4'b0001);  // store
    vecs[5] = mk(5, 6'b110000, 3, S_EXEC, 4'b0010);  // branch taken
    vecs[6] = mk(6, 6'b100000, 3, S_EXEC, 4'b0000);  // branch not taken
    vecs[7] = mk(7, 6'b110011, 3, S_EXEC, 4'b0010);  // branch, junk rw/m2r
    vecs[8] = mk(8, 6'b110101, 4, S_MEM,  4'b0001);  // memory beats branch

    {imem_ready, dmem_ready} = 2'b11;
    set_dec(6'b000000);
    do_reset();

    check("reset_state", 32'(state), 32'(S_IDLE));
    check("reset_retired", retired, 32'd0);
    check("reset_outputs", 32'({imem_req, ir_wr, dmem_req, dmem_we, rf_wr,
                                wb_sel_mem, pc_wr, pc_src_branch, fault}), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("idle_without_run", 32'(state), 32'(S_IDLE));
    check("idle_no_imem_req", 32'(imem_req), 32'd0);

    for (int i = 0; i < 9; i++) do_instr(vecs[i]);

    // Load whose data arrives in the last permitted MEM cycle.
    set_dec(6'b001011);
    dmem_ready = 1'b0;
    tgt = n_retire_seen + 1;
    exp_q.push_back(mk(20, 6'b001011, 8, S_WB, 4'b1100));
    n = 0;
    req_ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (state == S_MEM) begin
        n++;
        if (!dmem_req) req_ok = 1'b0;
        if (n == 4) dmem_ready = 1'b1;
      end else if (n > 0) begin
        break;
      end
    end
    check("load_mem_cycles", 32'(n), 32'd4);
    check("load_dmem_req_held", 32'(req_ok), 32'd1);
    wait_retire(tgt);

    // Reset asserted in the middle of a data access.
    set_dec(6'b001011);
    dmem_ready = 1'b0;
    for (int i = 0; i < 10 && state != S_MEM; i++) begin
      @(negedge clk); #1;
    end
    check("pre_reset_in_mem", 32'(state), 32'(S_MEM));
    reset = 1'b1;
    #1;
    check("midmem_reset_state", 32'(state), 32'(S_IDLE));
    check("midmem_reset_retired", retired, 32'd0);
    check("midmem_reset_dmem_req", 32'(dmem_req), 32'd0);
    exp_q.delete();
    exp_retired = '0;
    @(negedge clk); #1;
    reset = 1'b0;
    run = 1'b0;
    dmem_ready = 1'b1;

    // Simultaneous load+store faults in EXEC and stays faulted.
    set_dec(6'b001100);
    run = 1'b1;
    for (int i = 0; i < 10 && state != S_FAULT; i++) begin
      @(negedge clk); #1;
    end
    check("exec_fault_state", 32'(state), 32'(S_FAULT));
    run = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    run = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("fault_sticky_state", 32'(state), 32'(S_FAULT));
    check("fault_flag", 32'(fault), 32'd1);
    check("fault_outputs_low", 32'({imem_req, ir_wr, dmem_req, dmem_we, rf_wr,
                                    wb_sel_mem, pc_wr}), 32'd0);
    do_reset();
    check("fault_cleared", 32'(fault), 32'd0);

    // Fetch never answered: fault after exactly MEM_TIMEOUT fetch cycles.
    set_dec(6'b000001);
    imem_ready = 1'b0;
    run = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (state == S_FETCH) n++;
      if (state == S_FAULT) break;
    end
    check("timeout_fetch_cycles", 32'(n), 32'd4);
    check("timeout_state", 32'(state), 32'(S_FAULT));
    do_reset();

    // Fetch answered in the last permitted cycle: ready wins.
    set_dec(6'b000001);
    imem_ready = 1'b0;
    run = 1'b1;
    tgt = n_retire_seen + 1;
    exp_q.push_back(mk(21, 6'b000001, 7, S_WB, 4'b1000));
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (state == S_FETCH) begin
        n++;
        if (n == 4) begin
          imem_ready = 1'b1;
          #1;
          check("ir_wr_last_cycle", 32'(ir_wr), 32'd1);
        end
      end else if (n > 0) begin
        break;
      end
    end
    check("late_fetch_cycles", 32'(n), 32'd4);
    check("late_fetch_decode", 32'(state), 32'(S_DECODE));
    check("late_fetch_no_fault", 32'(fault), 32'd0);
    wait_retire(tgt);

    // Counter wrap on retire, with run dropped so the retire lands in IDLE.
    set_dec(6'b000001);
    tgt = n_retire_seen + 1;
    exp_q.push_back(mk(22, 6'b000001, 4, S_WB, 4'b1000));
    for (int i = 0; i < 10 && state != S_DECODE; i++) begin
      @(negedge clk); #1;
    end
    force dut.retired = 32'hFFFF_FFFF;
    #1;
    release dut.retired;
    exp_retired = 32'hFFFF_FFFF;
    run = 1'b0;
    wait_retire(tgt);
    check("wrap_idle_state", 32'(state), 32'(S_IDLE));
    check("wrap_no_fault", 32'(fault), 32'd0);
    @(negedge clk); #1;
    check("idle_after_run_drop", 32'(state), 32'(S_IDLE));
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cycle_controller.md
CYCLE_CONTROLLER -- requirements
Module: cycle_controller

Interface
REQ-001 The block SHALL have one parameter: MEM_TIMEOUT, default 16, maximum consecutive cycles a memory request may wait for ready before faulting (legal range 1..255).
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- run  in  1  start/continue enable, sampled in IDLE and at instruction retire
- imem_ready  in  1  instruction memory has data for the current fetch
- dmem_ready  in  1  data memory has completed the current access
- branch_stmt  in  1  decoded instruction is a branch
- mem_rd  in  1  decoded instruction is a load
- mem_wr  in  1  decoded instruction is a store
- mem_to_reg  in  1  writeback source is memory
- Reg_Wr  in  1  decoded instruction writes the register file
- branch_taken  in  1  ALU branch condition result
- imem_req  out  1  instruction fetch request
- ir_wr  out  1  instruction register load strobe
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write enable
- rf_wr  out  1  register file write strobe
- wb_sel_mem  out  1  writeback mux selects memory data
- pc_wr  out  1  PC update strobe
- pc_src_branch  out  1  PC update uses branch target
- fault  out  1  sticky fault flag
- state  out  3  current FSM state encoding
- retired  out  32  retired-instruction count

Function
REQ-003 The FSM SHALL have states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=6; encoding 7 is unreachable and SHALL go to FAULT on the next edge.
REQ-004 IDLE: all strobes low; run=1 -> FETCH, else stay.
REQ-005 FETCH: imem_req=1; imem_ready=1 -> ir_wr=1 combinationally that cycle, next DECODE.
REQ-006 DECODE: exactly one cycle, no strobes; next EXEC.
REQ-007 EXEC, evaluated in priority order:
- mem_rd=1 and mem_wr=1 -> FAULT
- mem_rd or mem_wr -> MEM
- branch_stmt -> pc_wr=1, pc_src_branch=branch_taken, retire
- otherwise -> WB
REQ-008 MEM: dmem_req=1, dmem_we=mem_wr. On dmem_ready=1:
- load -> WB
- store -> pc_wr=1, pc_src_branch=0, retire
REQ-009 WB: rf_wr=Reg_Wr, wb_sel_mem=mem_to_reg, pc_wr=1, pc_src_branch=0, retire.
REQ-010 Retire SHALL increment retired by 1 at that edge; next state is FETCH if run=1, else IDLE.
REQ-011 retired SHALL wrap 0xFFFFFFFF -> 0x00000000 without fault.
REQ-012 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle in that state with ready=0. If ready=0 in the cycle the counter equals MEM_TIMEOUT-1, next state is FAULT.
REQ-013 If ready=1 in the final permitted cycle, ready SHALL win over timeout.
REQ-014 FAULT: fault=1, all strobes and requests low, state held until reset; run is ignored.
REQ-015 ir_wr, pc_wr, rf_wr SHALL each be high for at most one cycle per instruction; pc_wr exactly once per retired instruction.
REQ-016 imem_req, dmem_req, dmem_we, wb_sel_mem, state and fault SHALL depend only on current state and registered values; strobes may depend combinationally on ready inputs.
REQ-017 Decoder inputs SHALL be sampled only in EXEC, MEM and WB; they are don't-care elsewhere.
REQ-018 Latency:
- ALU instruction = 4 cycles (FETCH..WB) with zero-wait memory
- branch = 3 cycles
- store = 4 cycles
- load = 5 cycles

Reset
REQ-019 reset=1 SHALL asynchronously force state=IDLE, wait counter=0, retired=0, fault=0, all strobes low, including mid-instruction and from FAULT.
REQ-020 After reset deasserts, the first FETCH SHALL begin no earlier than the first edge with run=1.

Verification
REQ-021 Bench SHALL cover:
- run=1, zero-wait memories, ALU op with Reg_Wr=1 -> states 1,2,3,5; rf_wr and pc_wr high in the WB cycle; retired=1 after 4 cycles.
- load, dmem_ready delayed 3 cycles, mem_to_reg=1 -> MEM held 4 cycles, dmem_req high throughout, wb_sel_mem=1 in WB, retired increments once.
- branch with branch_taken=1, then with 0 -> pc_src_branch=1, then 0; no WB state visited; 3 cycles each.
- imem_ready held 0, MEM_TIMEOUT=4 -> FAULT entered after 4 FETCH cycles; ready=1 in the 4th cycle instead -> DECODE, no fault.
- mem_rd=mem_wr=1 in EXEC -> FAULT, fault=1 sticky; reset asserted mid-MEM -> immediate IDLE, retired=0.
- retired preloaded via 2^32-1 retires (or forced) -> wraps to 0; run dropped at retire -> IDLE.
